// File: rtl/error_fetch_sequencer.sv
// rtl/error_fetch_sequencer.sv - Per-sample y/z issue and delta drain sequencer for one backprop error pass.
module error_fetch_sequencer #(
    parameter int NEURON_NUM          = 5,
    parameter int NEURON_OUTPUT_WIDTH = 10,
    parameter int ACTIVATION_WIDTH    = 9,
    parameter int DELTA_CELL_WIDTH    = 10,
    parameter int ADDR_WIDTH          = 8,
    parameter int SAMPLE_COUNT        = 200
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       done,
    output logic [ADDR_WIDTH-1:0]                      sample_addr,
    input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]     sample_data,
    input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]  z_in,
    input  logic                                       z_in_valid,
    output logic                                       z_in_ready,
    output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]     y,
    output logic                                       y_valid,
    input  logic                                       y_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]  z,
    output logic                                       z_valid,
    input  logic                                       z_ready,
    input  logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0]     delta_in,
    input  logic                                       delta_in_valid,
    output logic                                       delta_in_ready,
    output logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0]     delta_out,
    output logic                                       delta_out_valid,
    input  logic                                       delta_out_ready,
    input  logic                                       datapath_error,
    output logic                                       error,
    output logic [ADDR_WIDTH:0]                        error_count,
    output logic [ADDR_WIDTH:0]                        sample_index
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LATCH, S_ISSUE, S_DRAIN, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH+1)'(SAMPLE_COUNT - 1);

    state_t                                r_state;
    state_t                                w_next;
    logic [NEURON_NUM*ACTIVATION_WIDTH-1:0] r_y;
    logic                                  r_y_sent;
    logic                                  r_z_sent;
    logic                                  r_error;
    logic                                  r_mark;
    logic [ADDR_WIDTH:0]                   r_err_cnt;
    logic [ADDR_WIDTH:0]                   r_idx;
    logic [ADDR_WIDTH-1:0]                 r_addr;
    logic                                  w_y_hs;
    logic                                  w_z_hs;
    logic                                  w_d_hs;
    logic                                  w_last;

    assign w_y_hs = (r_state == S_ISSUE) && !r_y_sent && y_ready;
    assign w_z_hs = (r_state == S_ISSUE) && z_in_valid && !r_z_sent && z_ready;
    assign w_d_hs = (r_state == S_DRAIN) && delta_in_valid && delta_out_ready;
    assign w_last = (r_idx == LP_LAST);

    assign y            = r_y;
    assign z            = z_in;
    assign delta_out    = delta_in;
    assign sample_addr  = r_addr;
    assign sample_index = r_idx;
    assign error        = r_error;
    assign error_count  = r_err_cnt;

    always_comb begin
        w_next          = r_state;
        busy            = (r_state != S_IDLE);
        done            = 1'b0;
        y_valid         = 1'b0;
        z_valid         = 1'b0;
        z_in_ready      = 1'b0;
        delta_in_ready  = 1'b0;
        delta_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_READ;
            S_READ:  w_next = S_LATCH;
            S_LATCH: w_next = S_ISSUE;
            S_ISSUE: begin
                y_valid    = !r_y_sent;
                z_valid    = z_in_valid && !r_z_sent;
                z_in_ready = z_ready && !r_z_sent;
                // Leave once both sides are done, counting handshakes landing this cycle.
                if ((r_y_sent || w_y_hs) && (r_z_sent || w_z_hs)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                delta_in_ready  = delta_out_ready;
                delta_out_valid = delta_in_valid;
                if (w_d_hs) w_next = w_last ? S_DONE : S_READ;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_y       <= '0;
            r_y_sent  <= 1'b0;
            r_z_sent  <= 1'b0;
            r_error   <= 1'b0;
            r_mark    <= 1'b0;
            r_err_cnt <= '0;
            r_idx     <= '0;
            r_addr    <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_ISSUE || r_state == S_DRAIN) && datapath_error) begin
                r_error <= 1'b1;
                r_mark  <= 1'b1;
            end
            case (r_state)
                S_IDLE: if (start) begin
                    r_error   <= 1'b0;
                    r_err_cnt <= '0;
                    r_idx     <= '0;
                    r_addr    <= '0;
                end
                S_LATCH: begin
                    r_y      <= sample_data;
                    r_y_sent <= 1'b0;
                    r_z_sent <= 1'b0;
                    r_mark   <= 1'b0;
                end
                S_ISSUE: begin
                    if (w_y_hs) r_y_sent <= 1'b1;
                    if (w_z_hs) r_z_sent <= 1'b1;
                end
                S_DRAIN: if (w_d_hs) begin
                    r_idx  <= r_idx + 1'b1;
                    r_mark <= 1'b0;
                    if (!w_last) r_addr <= r_addr + 1'b1;
                    // An overflow on the handshake cycle itself still belongs to this sample.
                    if ((r_mark || datapath_error) && (r_err_cnt != '1))
                        r_err_cnt <= r_err_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_error_fetch_sequencer.sv
// tb/tb_error_fetch_sequencer.sv - Directed table-driven bench for error_fetch_sequencer.
module tb_error_fetch_sequencer;

    localparam int YW = 45;
    localparam int ZW = 50;
    localparam int DW = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start4, start1, y_ready, z_in_valid, z_ready;
    logic          delta_in_valid, delta_out_ready, datapath_error;
    logic [ZW-1:0] z_in;
    logic [DW-1:0] delta_in;

    logic          busy4, done4, z_in_ready4, y_valid4, z_valid4, delta_in_ready4, delta_out_valid4, error4;
    logic [7:0]    addr4;
    logic [YW-1:0] data4, y4;
    logic [ZW-1:0] z4;
    logic [DW-1:0] delta_out4;
    logic [8:0]    error_count4, sample_index4;

    logic          busy1, done1, z_in_ready1, y_valid1, z_valid1, delta_in_ready1, delta_out_valid1, error1;
    logic [7:0]    addr1;
    logic [YW-1:0] data1, y1;
    logic [ZW-1:0] z1;
    logic [DW-1:0] delta_out1;
    logic [8:0]    error_count1, sample_index1;

    error_fetch_sequencer #(.SAMPLE_COUNT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .sample_addr(addr4), .sample_data(data4), .z_in(z_in), .z_in_valid(z_in_valid),
        .z_in_ready(z_in_ready4), .y(y4), .y_valid(y_valid4), .y_ready(y_ready),
        .z(z4), .z_valid(z_valid4), .z_ready(z_ready), .delta_in(delta_in),
        .delta_in_valid(delta_in_valid), .delta_in_ready(delta_in_ready4),
        .delta_out(delta_out4), .delta_out_valid(delta_out_valid4),
        .delta_out_ready(delta_out_ready), .datapath_error(datapath_error),
        .error(error4), .error_count(error_count4), .sample_index(sample_index4)
    );

    error_fetch_sequencer #(.SAMPLE_COUNT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .sample_addr(addr1), .sample_data(data1), .z_in(z_in), .z_in_valid(z_in_valid),
        .z_in_ready(z_in_ready1), .y(y1), .y_valid(y_valid1), .y_ready(y_ready),
        .z(z1), .z_valid(z_valid1), .z_ready(z_ready), .delta_in(delta_in),
        .delta_in_valid(delta_in_valid), .delta_in_ready(delta_in_ready1),
        .delta_out(delta_out1), .delta_out_valid(delta_out_valid1),
        .delta_out_ready(delta_out_ready), .datapath_error(datapath_error),
        .error(error1), .error_count(error_count1), .sample_index(sample_index1)
    );

    function automatic logic [YW-1:0] pat(input logic [7:0] a);
        logic [YW-1:0] p;
        for (int i = 0; i < 5; i++) p[i*9 +: 9] = 9'(a * 5 + i + 1);
        return p;
    endfunction

    always @(posedge clk) begin
        data4 <= pat(addr4);
        data1 <= pat(addr1);
    end

    int yhs4 = 0, zhs4 = 0, donecnt4 = 0, donecnt1 = 0;
    logic addr1_moved = 1'b0;
    always @(posedge clk) begin
        if (y_valid4 && y_ready) yhs4++;
        if (z_valid4 && z_ready) zhs4++;
        if (done4) donecnt4++;
        if (done1) donecnt1++;
        if (addr1 != 8'd0) addr1_moved = 1'b1;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       start;
        logic       busy;
        logic       done;
        logic       yv;
        logic       zv;
        logic       dov;
        logic [7:0] addr;
        logic [8:0] idx;
    } vec_t;

    function automatic vec_t row(input logic s, input logic b, input logic d, input logic yv,
                                 input logic zv, input logic dov, input int a, input int ix);
        vec_t v;
        v.start = s; v.busy = b; v.done = d; v.yv = yv; v.zv = zv; v.dov = dov;
        v.addr = 8'(a); v.idx = 9'(ix);
        return v;
    endfunction

    vec_t tv[19];
    int   n, ybase, zbase, dbase;
    logic first_seen, pulsed;
    logic [DW-1:0] held;

    initial begin
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; y_ready = 1'b0; z_in_valid = 1'b0;
        z_ready = 1'b0; delta_in_valid = 1'b0; delta_out_ready = 1'b0; datapath_error = 1'b0;
        z_in = 50'h2_AAAA_5555_1234; delta_in = '0;
        tick; tick; tick;
        rst = 1'b0;
        #1;
        chk("rst_busy", 64'(busy4), 64'd0);
        chk("rst_done", 64'(done4), 64'd0);
        chk("rst_y", 64'(y4), 64'd0);
        chk("rst_yv", 64'(y_valid4), 64'd0);
        chk("rst_err", 64'(error4), 64'd0);
        chk("rst_ecnt", 64'(error_count4), 64'd0);
        chk("rst_idx", 64'(sample_index4), 64'd0);
        chk("rst_addr", 64'(addr4), 64'd0);

        // Full pass, everything ready; row 6 raises start mid-pass, which must be ignored.
        tv[0]  = row(1, 0, 0, 0, 0, 0, 0, 0);
        tv[1]  = row(0, 1, 0, 0, 0, 0, 0, 0);
        tv[2]  = row(0, 1, 0, 0, 0, 0, 0, 0);
        tv[3]  = row(0, 1, 0, 1, 1, 0, 0, 0);
        tv[4]  = row(0, 1, 0, 0, 0, 1, 0, 0);
        tv[5]  = row(0, 1, 0, 0, 0, 0, 1, 1);
        tv[6]  = row(1, 1, 0, 0, 0, 0, 1, 1);
        tv[7]  = row(0, 1, 0, 1, 1, 0, 1, 1);
        tv[8]  = row(0, 1, 0, 0, 0, 1, 1, 1);
        tv[9]  = row(0, 1, 0, 0, 0, 0, 2, 2);
        tv[10] = row(0, 1, 0, 0, 0, 0, 2, 2);
        tv[11] = row(0, 1, 0, 1, 1, 0, 2, 2);
        tv[12] = row(0, 1, 0, 0, 0, 1, 2, 2);
        tv[13] = row(0, 1, 0, 0, 0, 0, 3, 3);
        tv[14] = row(0, 1, 0, 0, 0, 0, 3, 3);
        tv[15] = row(0, 1, 0, 1, 1, 0, 3, 3);
        tv[16] = row(0, 1, 0, 0, 0, 1, 3, 3);
        tv[17] = row(0, 1, 1, 0, 0, 0, 3, 4);
        tv[18] = row(0, 0, 0, 0, 0, 0, 3, 4);

        y_ready = 1'b1; z_ready = 1'b1; z_in_valid = 1'b1;
        delta_in_valid = 1'b1; delta_out_ready = 1'b1;
        dbase = donecnt4;
        for (int i = 0; i < 19; i++) begin
            tick;
            start4   = tv[i].start;
            delta_in = {5{10'(i + 100)}};
            #1;
            chk($sformatf("tbl%0d_busy", i), 64'(busy4), 64'(tv[i].busy));
            chk($sformatf("tbl%0d_done", i), 64'(done4), 64'(tv[i].done));
            chk($sformatf("tbl%0d_yv", i), 64'(y_valid4), 64'(tv[i].yv));
            chk($sformatf("tbl%0d_zv", i), 64'(z_valid4), 64'(tv[i].zv));
            chk($sformatf("tbl%0d_dov", i), 64'(delta_out_valid4), 64'(tv[i].dov));
            chk($sformatf("tbl%0d_dir", i), 64'(delta_in_ready4), 64'(tv[i].dov));
            chk($sformatf("tbl%0d_addr", i), 64'(addr4), 64'(tv[i].addr));
            chk($sformatf("tbl%0d_idx", i), 64'(sample_index4), 64'(tv[i].idx));
            if (tv[i].yv) begin
                chk($sformatf("tbl%0d_y", i), 64'(y4), 64'(pat(tv[i].addr)));
                chk($sformatf("tbl%0d_z", i), 64'(z4), 64'(z_in));
            end
            if (tv[i].dov) chk($sformatf("tbl%0d_dout", i), 64'(delta_out4), 64'(delta_in));
        end
        start4 = 1'b0;
        chk("p1_err", 64'(error4), 64'd0);
        chk("p1_ecnt", 64'(error_count4), 64'd0);
        chk("p1_done_pulses", 64'(donecnt4 - dbase), 64'd1);

        // Late z in sample 0, then downstream backpressure in its drain.
        tick;
        z_in_valid = 1'b0; delta_out_ready = 1'b0;
        ybase = yhs4; zbase = zhs4;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        n = 0;
        while (!y_valid4 && n < 10) begin tick; n++; end
        chk("p2_reach_issue", 64'(y_valid4), 64'd1);
        chk("p2_zv_wait", 64'(z_valid4), 64'd0);
        tick;
        for (int k = 0; k < 5; k++) begin
            chk("p2_y_not_resent", 64'(y_valid4), 64'd0);
            chk("p2_zv_low", 64'(z_valid4), 64'd0);
            tick;
        end
        z_in_valid = 1'b1; z_ready = 1'b0;
        #1;
        chk("p2_zv_up", 64'(z_valid4), 64'd1);
        chk("p2_zinr_no_zready", 64'(z_in_ready4), 64'd0);
        tick;
        z_ready = 1'b1;
        #1;
        chk("p2_zinr_zready", 64'(z_in_ready4), 64'd1);
        tick;
        held = 50'h1_2345_6789_ABCD;
        delta_in = held;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("p2_bp_dov", 64'(delta_out_valid4), 64'd1);
            chk("p2_bp_dir", 64'(delta_in_ready4), 64'd0);
            chk("p2_bp_dout", 64'(delta_out4), 64'(held));
            chk("p2_bp_idx", 64'(sample_index4), 64'd0);
            tick;
        end
        delta_out_ready = 1'b1;
        #1;
        chk("p2_bp_release", 64'(delta_in_ready4), 64'd1);
        tick;
        chk("p2_idx_adv", 64'(sample_index4), 64'd1);
        n = 0;
        while (!done4 && n < 100) begin tick; n++; end
        chk("p2_done_seen", 64'(done4), 64'd1);
        chk("p2_y_xfers", 64'(yhs4 - ybase), 64'd4);
        chk("p2_z_xfers", 64'(zhs4 - zbase), 64'd4);
        chk("p2_idx_final", 64'(sample_index4), 64'd4);
        tick;
        chk("p2_busy_after_done", 64'(busy4), 64'd0);

        // Overflow during samples 1 and 2, then a new start clears the collection.
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        first_seen = 1'b0;
        n = 0;
        while (!done4 && n < 100) begin
            pulsed = y_valid4 && (sample_index4 == 9'd1 || sample_index4 == 9'd2);
            datapath_error = pulsed;
            if (!first_seen && sample_index4 == 9'd1 && !pulsed) chk("p3_err_before", 64'(error4), 64'd0);
            tick;
            if (pulsed && !first_seen) begin
                chk("p3_err_first", 64'(error4), 64'd1);
                first_seen = 1'b1;
            end
            n++;
        end
        datapath_error = 1'b0;
        chk("p3_done_seen", 64'(done4), 64'd1);
        chk("p3_err_sticky", 64'(error4), 64'd1);
        chk("p3_ecnt", 64'(error_count4), 64'd2);
        tick;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        chk("p3_err_cleared", 64'(error4), 64'd0);
        chk("p3_ecnt_cleared", 64'(error_count4), 64'd0);
        chk("p3_idx_cleared", 64'(sample_index4), 64'd0);
        n = 0;
        while (!done4 && n < 100) begin tick; n++; end
        chk("p3b_done_seen", 64'(done4), 64'd1);
        tick;

        // Reset while issuing sample 2, then restart from address 0.
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        n = 0;
        while (!(y_valid4 && addr4 == 8'd2) && n < 50) begin tick; n++; end
        chk("p4_reach_issue2", 64'(y_valid4 && addr4 == 8'd2), 64'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("p4_busy", 64'(busy4), 64'd0);
        chk("p4_yv", 64'(y_valid4), 64'd0);
        chk("p4_zv", 64'(z_valid4), 64'd0);
        chk("p4_zinr", 64'(z_in_ready4), 64'd0);
        chk("p4_dov", 64'(delta_out_valid4), 64'd0);
        chk("p4_dir", 64'(delta_in_ready4), 64'd0);
        chk("p4_addr", 64'(addr4), 64'd0);
        chk("p4_idx", 64'(sample_index4), 64'd0);
        chk("p4_y", 64'(y4), 64'd0);
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        n = 0;
        while (!y_valid4 && n < 10) begin tick; n++; end
        chk("p4_restart_addr", 64'(addr4), 64'd0);
        chk("p4_restart_y", 64'(y4), 64'(pat(8'd0)));
        n = 0;
        while (!done4 && n < 100) begin tick; n++; end
        chk("p4_done_seen", 64'(done4), 64'd1);
        tick;

        // Single-sample pass.
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        n = 0;
        while (!y_valid1 && n < 10) begin tick; n++; end
        chk("s1_yv", 64'(y_valid1), 64'd1);
        chk("s1_y", 64'(y1), 64'(pat(8'd0)));
        n = 0;
        while (!done1 && n < 20) begin tick; n++; end
        chk("s1_done_seen", 64'(done1), 64'd1);
        chk("s1_idx", 64'(sample_index1), 64'd1);
        chk("s1_addr", 64'(addr1), 64'd0);
        tick;
        chk("s1_busy", 64'(busy1), 64'd0);
        chk("s1_addr_moved", 64'(addr1_moved), 64'd0);
        chk("s1_done_pulses", 64'(donecnt1), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
